// File: rtl/decode_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_pkg
// Description : Opcode/function constants, field positions and decoded-entry
//               record shared by the decode stage and its instruction decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_stage_pkg;

    localparam logic [5:0] c_op_special = 6'd0;
    localparam logic [5:0] c_op_addi    = 6'd1;
    localparam logic [5:0] c_op_load    = 6'd3;
    localparam logic [5:0] c_op_andi    = 6'd4;
    localparam logic [5:0] c_op_ori     = 6'd5;
    localparam logic [5:0] c_op_xori    = 6'd6;
    localparam logic [5:0] c_op_jump    = 6'd41;

    localparam logic [4:0] c_fn_sll  = 5'd0;
    localparam logic [4:0] c_fn_srl  = 5'd2;
    localparam logic [4:0] c_fn_add  = 5'd8;
    localparam logic [4:0] c_fn_sub  = 5'd9;
    localparam logic [4:0] c_fn_and  = 5'd10;
    localparam logic [4:0] c_fn_or   = 5'd11;
    localparam logic [4:0] c_fn_xor  = 5'd16;
    localparam logic [4:0] c_fn_slt  = 5'd17;
    localparam logic [4:0] c_fn_sltu = 5'd18;

    localparam int c_op_hi    = 31;
    localparam int c_op_lo    = 26;
    localparam int c_rs_hi    = 25;
    localparam int c_rs_lo    = 21;
    localparam int c_rt_hi    = 20;
    localparam int c_rt_lo    = 16;
    localparam int c_rd_hi    = 15;
    localparam int c_rd_lo    = 11;
    localparam int c_aux_hi   = 10;
    localparam int c_aux_lo   = 0;
    localparam int c_fn_hi    = 4;
    localparam int c_imm16_hi = 15;
    localparam int c_imm26_hi = 25;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [10:0] aux;
        logic [31:0] imm;
        logic        illegal;
    } decoded_t;

    localparam int c_entry_w = 97;

    function automatic logic is_alu_fn(input logic [4:0] fn);
        case (fn)
            c_fn_sll, c_fn_srl, c_fn_add, c_fn_sub, c_fn_and,
            c_fn_or, c_fn_xor, c_fn_slt, c_fn_sltu: is_alu_fn = 1'b1;
            default:                                is_alu_fn = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_inst_decode.sv
`default_nettype none
// ============================================================================
// Module      : inst_decode
// Description : Combinational field split, immediate extension and legality
//               check of one raw instruction word.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_decode
    import decode_stage_pkg::*;
(
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    output decoded_t    dec
);

    logic [5:0]  w_op;
    logic [10:0] w_aux;

    assign w_op  = inst[c_op_hi:c_op_lo];
    assign w_aux = inst[c_aux_hi:c_aux_lo];

    always_comb begin
        dec         = '0;
        dec.pc      = pc;
        dec.op      = w_op;
        dec.rs      = inst[c_rs_hi:c_rs_lo];
        dec.rt      = inst[c_rt_hi:c_rt_lo];
        dec.rd      = inst[c_rd_hi:c_rd_lo];
        dec.aux     = w_aux;
        dec.imm     = '0;
        dec.illegal = 1'b0;
        case (w_op)
            c_op_special:
                dec.illegal = !is_alu_fn(w_aux[c_fn_hi:0]);
            c_op_addi, c_op_load:
                dec.imm = {{16{inst[c_imm16_hi]}}, inst[c_imm16_hi:0]};
            c_op_andi, c_op_ori, c_op_xori:
                dec.imm = {16'd0, inst[c_imm16_hi:0]};
            c_op_jump:
                dec.imm = {6'd0, inst[c_imm26_hi:0]};
            default:
                dec.illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Instruction decode with a 2-entry skid buffer of decoded
//               records between fetch and execute.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst,
    output logic        if_ready,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [5:0]  op,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [10:0] aux,
    output logic [31:0] imm_dpl,
    output logic        illegal
);

    decoded_t   w_dec;
    decoded_t   r_head;
    decoded_t   r_tail;
    logic [1:0] r_count;
    logic       w_push;
    logic       w_pop;

    inst_decode u_inst_decode (
        .inst (if_inst),
        .pc   (if_pc),
        .dec  (w_dec)
    );

    assign if_ready = (r_count != 2'd2) && !flush;
    assign id_valid = (r_count != 2'd0);
    assign w_push   = if_valid && if_ready;
    assign w_pop    = id_valid && ex_ready;

    // Head register feeds the outputs directly; it is only overwritten when a
    // newer entry must take its place, so fields hold while the buffer is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (flush) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= w_dec;
                    end else begin
                        r_tail <= w_dec;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                    end
                    r_count <= r_count - 2'd1;
                end
                // Push with pop is only reachable at count 1.
                2'b11: begin
                    r_head <= w_dec;
                end
                default: begin
                end
            endcase
        end
    end

    assign id_pc   = r_head.pc;
    assign op      = r_head.op;
    assign rs      = r_head.rs;
    assign rt      = r_head.rt;
    assign rd      = r_head.rd;
    assign aux     = r_head.aux;
    assign imm_dpl = r_head.imm;
    assign illegal = r_head.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Scoreboard bench for decode_stage; a reference decoder and a
//               queue model of the skid buffer predict every head entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;
    logic        flush;
    logic        ex_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [10:0] aux;
    logic [31:0] imm_dpl;
    logic        illegal;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [10:0] aux;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    logic [96:0] obs_bits;
    int          n_checks = 0;
    int          n_fail   = 0;

    assign obs_bits = {id_pc, op, rs, rt, rd, aux, imm_dpl, illegal};

    always #5 clk = ~clk;

    decode_stage dut (
        .clk      (clk),
        .rst      (rst),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_ready (if_ready),
        .flush    (flush),
        .ex_ready (ex_ready),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .op       (op),
        .rs       (rs),
        .rt       (rt),
        .rd       (rd),
        .aux      (aux),
        .imm_dpl  (imm_dpl),
        .illegal  (illegal)
    );

    function automatic exp_t ref_decode(input logic [31:0] pc, input logic [31:0] w);
        exp_t e;
        e.pc  = pc;
        e.op  = w[31:26];
        e.rs  = w[25:21];
        e.rt  = w[20:16];
        e.rd  = w[15:11];
        e.aux = w[10:0];
        e.imm = 32'd0;
        e.ill = 1'b1;
        if (w[31:26] == 6'd0) begin
            e.ill = !(w[4:0] == 5'd0 || w[4:0] == 5'd2 || (w[4:0] >= 5'd8 && w[4:0] <= 5'd11)
                      || (w[4:0] >= 5'd16 && w[4:0] <= 5'd18));
        end else if (w[31:26] == 6'd1 || w[31:26] == 6'd3) begin
            e.ill = 1'b0;
            e.imm = $signed(w[15:0]);
        end else if (w[31:26] >= 6'd4 && w[31:26] <= 6'd6) begin
            e.ill = 1'b0;
            e.imm = {16'h0000, w[15:0]};
        end else if (w[31:26] == 6'd41) begin
            e.ill = 1'b0;
            e.imm = {6'd0, w[25:0]};
        end
        return e;
    endfunction

    // One clock edge with the queue model updated from the inputs in force.
    task automatic tick();
        bit do_pop;
        bit do_push;
        do_pop  = (exp_q.size() != 0) && ex_ready;
        do_push = if_valid && (exp_q.size() < 2) && !flush;
        @(posedge clk);
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(ref_decode(if_pc, if_inst));
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_valid = 1'b1; if_pc = 32'h44; if_inst = 32'h0441FFFF;
        flush = 1'b0; ex_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0; if_valid = 1'b0;
        n_checks++;
        if (id_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", id_valid);
        end
        n_checks++;
        if (obs_bits !== 97'd0) begin
            n_fail++; $display("FAIL reset_fields: got %h want 0", obs_bits);
        end
        n_checks++;
        if (if_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_if_ready: got %b want 1", if_ready);
        end
    endtask

    task automatic test_decode();
        logic [31:0] t_inst [6];
        logic [31:0] t_imm  [6];
        logic [5:0]  t_op   [6];
        logic        t_ill  [6];
        t_inst = '{32'h0441FFFF, 32'h14038000, 32'hA4000010, 32'h00201110, 32'h08000000, 32'h00000003};
        t_imm  = '{32'hFFFFFFFF, 32'h00008000, 32'h00000010, 32'h0, 32'h0, 32'h0};
        t_op   = '{6'd1, 6'd5, 6'd41, 6'd0, 6'd2, 6'd0};
        t_ill  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            if_valid = 1'b1; if_pc = 32'h10 + 32'(4 * i); if_inst = t_inst[i]; ex_ready = 1'b0;
            tick();
            if_valid = 1'b0;
            n_checks++;
            if (id_valid !== 1'b1 || exp_q.size() != 1) begin
                n_fail++; $display("FAIL dec_valid[%0d]: got %b want 1", i, id_valid);
            end else begin
                n_checks++;
                if (obs_bits !== exp_q[0]) begin
                    n_fail++; $display("FAIL dec_head[%0d]: got %h want %h", i, obs_bits, exp_q[0]);
                end
            end
            n_checks++;
            if (op !== t_op[i] || imm_dpl !== t_imm[i] || illegal !== t_ill[i]) begin
                n_fail++;
                $display("FAIL dec_table[%0d]: got op=%0d imm=%h ill=%b want op=%0d imm=%h ill=%b",
                         i, op, imm_dpl, illegal, t_op[i], t_imm[i], t_ill[i]);
            end
            ex_ready = 1'b1;
            tick();
            ex_ready = 1'b0;
            n_checks++;
            if (id_valid !== 1'b0) begin
                n_fail++; $display("FAIL dec_drain[%0d]: got %b want 0", i, id_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] t_inst [3];
        logic [31:0] out_pc[$];
        int sent;
        t_inst = '{32'h20A50004, 32'h00853020, 32'h30C7FFFF};
        sent = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (sent == 3 && exp_q.size() == 0) break;
            if_valid = (sent < 3);
            if_pc    = 32'h100 + 32'(4 * sent);
            if_inst  = t_inst[sent % 3];
            ex_ready = (cyc >= 3);
            #1;
            n_checks++;
            if (if_ready !== (exp_q.size() != 2)) begin
                n_fail++; $display("FAIL b2b_if_ready[%0d]: got %b want %b", cyc, if_ready, exp_q.size() != 2);
            end
            n_checks++;
            if (id_valid !== (exp_q.size() != 0)) begin
                n_fail++; $display("FAIL b2b_valid[%0d]: got %b want %b", cyc, id_valid, exp_q.size() != 0);
            end else if (exp_q.size() != 0) begin
                n_checks++;
                if (obs_bits !== exp_q[0]) begin
                    n_fail++; $display("FAIL b2b_head[%0d]: got %h want %h", cyc, obs_bits, exp_q[0]);
                end
                if (ex_ready) out_pc.push_back(exp_q[0].pc);
            end
            if (if_valid && exp_q.size() < 2) sent++;
            tick();
        end
        if_valid = 1'b0; ex_ready = 1'b0;
        n_checks++;
        if (out_pc.size() != 3 || sent != 3) begin
            n_fail++; $display("FAIL b2b_count: got %0d want 3", out_pc.size());
        end else begin
            n_checks++;
            if (out_pc[0] !== 32'h100 || out_pc[1] !== 32'h104 || out_pc[2] !== 32'h108) begin
                n_fail++; $display("FAIL b2b_order: got %h %h %h want 100 104 108", out_pc[0], out_pc[1], out_pc[2]);
            end
        end
    endtask

    task automatic test_flush();
        ex_ready = 1'b0; if_valid = 1'b1;
        if_pc = 32'h200; if_inst = 32'h04220001; tick();
        if_pc = 32'h204; if_inst = 32'h04430002; tick();
        n_checks++;
        if (if_ready !== 1'b0 || exp_q.size() != 2) begin
            n_fail++; $display("FAIL flush_full: got if_ready=%b want 0", if_ready);
        end
        flush = 1'b1; ex_ready = 1'b1; if_pc = 32'h208; if_inst = 32'h04640003;
        #1;
        n_checks++;
        if (if_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_if_ready: got %b want 0", if_ready);
        end
        tick();
        flush = 1'b0; if_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (id_valid !== 1'b0) begin
                n_fail++; $display("FAIL flush_valid[%0d]: got %b pc=%h want 0", i, id_valid, id_pc);
            end
            tick();
        end
        ex_ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        ex_ready = 1'b0; if_valid = 1'b1; if_pc = 32'h300; if_inst = 32'h14038000;
        tick();
        rst = 1'b1; ex_ready = 1'b1; if_pc = 32'h304; if_inst = 32'hA4000010;
        tick();
        rst = 1'b0; if_valid = 1'b0; ex_ready = 1'b0;
        n_checks++;
        if (id_valid !== 1'b0 || obs_bits !== 97'd0) begin
            n_fail++; $display("FAIL rst_mid: got valid=%b fields=%h want 0", id_valid, obs_bits);
        end
        if_valid = 1'b1; if_pc = 32'h308; if_inst = 32'h00201110;
        tick();
        if_valid = 1'b0;
        n_checks++;
        if (id_valid !== 1'b1 || exp_q.size() != 1) begin
            n_fail++; $display("FAIL rst_repush_valid: got %b want 1", id_valid);
        end else begin
            n_checks++;
            if (obs_bits !== exp_q[0]) begin
                n_fail++; $display("FAIL rst_repush_head: got %h want %h", obs_bits, exp_q[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high; the ports are clk and rst.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 if_valid  in  1  fetch presents an instruction.
REQ-005 if_pc  in  32  word address of the presented instruction.
REQ-006 if_inst  in  32  raw instruction word.
REQ-007 if_ready  out  1  decode can accept an instruction this cycle.
REQ-008 flush  in  1  discard all buffered and incoming instructions (branch/jump redirect).
REQ-009 ex_ready  in  1  execute stage consumes the head entry this cycle.
REQ-010 id_valid  out  1  head entry is valid.
REQ-011 id_pc  out  32  pc of the head entry.
REQ-012 op  out  6  opcode field, inst[31:26].
REQ-013 rs, rt, rd  out  5 each  inst[25:21], inst[20:16], inst[15:11].
REQ-014 aux  out  11  inst[10:0]; aux[4:0] is the ALU function code, aux[10:6] is the shift amount.
REQ-015 imm_dpl  out  32  extended immediate.
REQ-016 illegal  out  1  head entry does not decode to a supported operation.

Function
REQ-017 The block SHALL decode each instruction combinationally at the input and store the decoded fields, not the raw word, in a 2-entry FIFO (skid buffer).
REQ-018 The block SHALL sign-extend inst[15:0] to imm_dpl for op 1 and op 3, zero-extend inst[15:0] for op 4, 5 and 6, zero-extend inst[25:0] for op 41, and drive 0 for all other ops.
REQ-019 illegal SHALL be 1 when op is not in {0,1,3,4,5,6,41}, or when op=0 and aux[4:0] is not in {0,2,8,9,10,11,16,17,18}; an illegal entry SHALL still be buffered and presented.
REQ-020 An input transfer SHALL occur on a rising edge with if_valid=1 and if_ready=1; an output transfer SHALL occur on a rising edge with id_valid=1 and ex_ready=1.
REQ-021 Occupancy count (0..2) SHALL drive the handshake: if_ready = (count!=2) and not flush; id_valid = (count!=0).
REQ-022 Latency SHALL be 1 cycle: an instruction accepted at edge N is presented on id_* from edge N into an empty buffer.
REQ-023 The id_* outputs SHALL always reflect the oldest entry, and order SHALL be preserved.
REQ-024 A simultaneous push and pop at count=1 SHALL leave count=1, with the new entry at the head after the edge.
REQ-025 A simultaneous push and pop at count=0 SHALL NOT occur, because id_valid=0; a push at count=0 gives count=1.
REQ-026 At count=2, if_ready=0; a pop moves the second entry to the head and gives count=1.
REQ-027 flush=1 SHALL force count to 0 at the next edge and drop any concurrent input, regardless of ex_ready.
REQ-028 id_* field outputs SHALL hold their last value when id_valid=0; the consumer ignores them.

Reset
REQ-029 While rst=1 at an edge, count SHALL become 0 and all storage and id_* outputs SHALL become 0.
REQ-030 rst SHALL take priority over flush, push and pop; an instruction presented during reset is not accepted.
REQ-031 rst asserted mid-stream SHALL discard all entries, and the first post-reset push SHALL appear as if the buffer had never held data.

Structure
REQ-032 A shared package SHALL hold the opcode constants (0,1,3,4,5,6,41), the ALU function codes (0,2,8,9,10,11,16,17,18), the field bit positions, and the decoded-entry record width.
REQ-033 The field split, immediate extension and illegal check SHALL be a combinational sub-module named inst_decode; decode_stage instantiates it plus the FIFO and control logic.

Verification
REQ-034 Reset, then push 0x0441FFFF at pc 0x10 with ex_ready=0 -> next cycle id_valid=1, op=1, rs=2, rt=1, imm_dpl=0xFFFFFFFF, illegal=0, id_pc=0x10.
REQ-035 Push 0x14038000 -> op=5, rt=3, imm_dpl=0x00008000; push 0xA4000010 -> op=41, imm_dpl=0x00000010.
REQ-036 Push 0x00201110 -> op=0, rs=1, rd=2, aux=0x110, illegal=0; push 0x08000000 -> illegal=1, imm_dpl=0; push 0x00000003 -> illegal=1.
REQ-037 Hold ex_ready=0 and push 3 back-to-back -> if_ready=0 after 2 accepts and the third is held; raise ex_ready -> instructions exit in order A,B,C with no loss or duplication.
REQ-038 At count=2, assert flush together with if_valid=1 -> next cycle id_valid=0, count=0, and the incoming instruction is never presented.
REQ-039 At count=1, assert rst together with push and pop -> next cycle id_valid=0 and all outputs 0.
